mem_port_arbiter: RTL and testbench



---
 rtl/cpu_mem_pkg.sv | 23 ++
 rtl/mem_arb_perf.sv | 38 +++
 rtl/mem_port_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the memory port arbiter.
//   arb_state_e : transaction sequencer states (idle, issue, wait, response)
//   owner_e     : which requester owns the transaction in flight
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths
package cpu_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } arb_state_e;

  typedef enum logic [1:0] {
    OwnNone,
    OwnInstr,
    OwnData
  } owner_e;

endpackage

// File: rtl/mem_arb_perf.sv
// Performance counters for the memory port arbiter.
// Counts instruction grants, data grants and stall-high cycles; all three wrap around and
// are cleared by reset.
// Ports:
//   clock, reset            : clock and asynchronous active-high reset
//   if_gnt, d_gnt, stall    : events to count (sampled each rising edge)
//   perf_if_gnt, perf_d_gnt,
//   perf_stall              : 32-bit counter values
module mem_arb_perf (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_gnt,
  input  logic        d_gnt,
  input  logic        stall,
  output logic [31:0] perf_if_gnt,
  output logic [31:0] perf_d_gnt,
  output logic [31:0] perf_stall
);

  logic [31:0] if_cnt_q, d_cnt_q, stall_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      if_cnt_q    <= '0;
      d_cnt_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (if_gnt) if_cnt_q    <= if_cnt_q + 32'd1;
      if (d_gnt)  d_cnt_q     <= d_cnt_q + 32'd1;
      if (stall)  stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_if_gnt = if_cnt_q;
  assign perf_d_gnt  = d_cnt_q;
  assign perf_stall  = stall_cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and load/store access to one single-ported, fixed-latency
// memory. One transaction at a time: grant (IDLE) -> strobe (ISSUE) -> MEM_LAT cycles
// (WAIT) -> one-cycle response pulse (RESP).
// Optional feature macro: ARB_PERF_CNT_EN adds live grant/stall counters; without it the
// perf_* ports read 0.
// Ports:
//   clock, reset                      : clock, asynchronous active-high reset
//   if_req/if_addr/if_gnt             : fetch request, address, combinational grant
//   if_rvalid/if_rdata                : fetch response pulse and instruction
//   d_req/d_we/d_addr/d_wdata/d_gnt   : load/store request side, combinational grant
//   d_rvalid/d_rdata                  : load data or store acknowledge pulse
//   m_req/m_we/m_addr/m_wdata/m_rdata : memory side, registered strobe
//   stall                             : pipeline stall request
//   perf_if_gnt/perf_d_gnt/perf_stall : performance counters
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              stall,
  output logic [31:0]       perf_if_gnt,
  output logic [31:0]       perf_d_gnt,
  output logic [31:0]       perf_stall
);

  localparam int unsigned CntW = $clog2(MEM_LAT + 1);
  localparam int unsigned StrW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  arb_state_e state_q, state_d;
  owner_e     owner_q, owner_d;
  logic [StrW-1:0] streak_q, streak_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic grant_i, grant_d;

  logic              m_req_q, m_we_q, we_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q, if_rdata_q, d_rdata_q;
  logic              if_rvalid_q, d_rvalid_q;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    cnt_d    = cnt_q;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Grants are combinational, so they must be masked while reset is held.
        if (!reset) begin
          if (d_req && !(if_req && streak_q == StrW'(STARVE_MAX))) begin
            grant_d = 1'b1;
          end else if (if_req) begin
            grant_i = 1'b1;
          end
        end
        if (grant_d) begin
          owner_d = OwnData;
          state_d = StIssue;
          if (!if_req) begin
            streak_d = '0;
          end else if (streak_q != StrW'(STARVE_MAX)) begin
            streak_d = streak_q + 1'b1;
          end
        end else if (grant_i) begin
          owner_d  = OwnInstr;
          state_d  = StIssue;
          streak_d = '0;
        end
      end
      StIssue: begin
        cnt_d   = CntW'(MEM_LAT);
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
        owner_d = OwnNone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      owner_q  <= OwnNone;
      streak_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      cnt_q    <= cnt_d;
    end
  end

  // The memory strobe registers are loaded at the grant edge, so they are live exactly
  // during ISSUE and fall back to 0 on the following edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      we_q        <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if (grant_d) begin
        m_req_q   <= 1'b1;
        m_we_q    <= d_we;
        we_q      <= d_we;
        m_addr_q  <= d_addr;
        m_wdata_q <= d_wdata;
      end else if (grant_i) begin
        m_req_q  <= 1'b1;
        we_q     <= 1'b0;
        m_addr_q <= if_addr;
      end
      if (state_q == StWait && cnt_q == CntW'(1)) begin
        if (owner_q == OwnInstr) begin
          if_rvalid_q <= 1'b1;
          if_rdata_q  <= m_rdata;
        end else if (owner_q == OwnData) begin
          d_rvalid_q <= 1'b1;
          // A store only acknowledges; the last load data stays visible.
          if (!we_q) d_rdata_q <= m_rdata;
        end
      end
    end
  end

  assign if_gnt    = grant_i;
  assign d_gnt     = grant_d;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign stall     = !reset && ((state_q != StIdle) || (if_req && d_req));

`ifdef ARB_PERF_CNT_EN
  mem_arb_perf u_perf (
    .clock       (clock),
    .reset       (reset),
    .if_gnt      (grant_i),
    .d_gnt       (grant_d),
    .stall       (stall),
    .perf_if_gnt (perf_if_gnt),
    .perf_d_gnt  (perf_d_gnt),
    .perf_stall  (perf_stall)
  );
`else
  assign perf_if_gnt = '0;
  assign perf_d_gnt  = '0;
  assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int unsigned LAT  = 2;
  localparam int unsigned SMAX = 4;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
`ifdef ARB_PERF_CNT_EN
  localparam logic [31:0] EXP_PIF = 32'd1, EXP_PD = 32'd1, EXP_PST = 32'd9;
`else
  localparam logic [31:0] EXP_PIF = 32'd0, EXP_PD = 32'd0, EXP_PST = 32'd0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, m_req, m_we, stall;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata, perf_if_gnt, perf_d_gnt, perf_stall;

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .MEM_LAT    (LAT),
    .STARVE_MAX (SMAX)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_gnt      (if_gnt),
    .if_rvalid   (if_rvalid),
    .if_rdata    (if_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_gnt       (d_gnt),
    .d_rvalid    (d_rvalid),
    .d_rdata     (d_rdata),
    .m_req       (m_req),
    .m_we        (m_we),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_rdata     (m_rdata),
    .stall       (stall),
    .perf_if_gnt (perf_if_gnt),
    .perf_d_gnt  (perf_d_gnt),
    .perf_stall  (perf_stall)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model: read data is valid only in the cycle MEM_LAT after the strobe.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_val;
  int age;
  bit pend;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  initial m_rdata = JUNK;
  always @(negedge clock) begin
    if (reset) begin
      pend    = 1'b0;
      m_rdata = JUNK;
    end else if (m_req) begin
      if (m_we) mem[m_addr] = m_wdata;
      rd_val  = mem_rd(m_addr);
      pend    = 1'b1;
      age     = 0;
      m_rdata = JUNK;
    end else if (pend) begin
      age++;
      if (age == int'(LAT)) begin
        m_rdata = rd_val;
        pend    = 1'b0;
      end else begin
        m_rdata = JUNK;
      end
    end else begin
      m_rdata = JUNK;
    end
  end

  // Scoreboard: expectations pushed at grant, popped at strobe and at response.
  typedef struct {bit is_data; logic [31:0] data; int due;} rsp_t;
  typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata; int due;} iss_t;
  rsp_t sb[$];
  iss_t iq[$];
  bit glog[$];
  logic [31:0] exp_d_rdata = '0;

  always @(negedge clock) begin
    rsp_t r;
    iss_t s;
    if (reset) begin
      sb.delete();
      iq.delete();
      exp_d_rdata = '0;
    end else begin
      check("gnt_excl", 64'(if_gnt & d_gnt), 64'd0);
      if (d_gnt) begin
        glog.push_back(1'b1);
        s.addr = d_addr; s.we = d_we; s.wdata = d_wdata; s.due = cyc + 1;
        iq.push_back(s);
        if (!d_we) exp_d_rdata = mem_rd(d_addr);
        r.is_data = 1'b1; r.data = exp_d_rdata; r.due = cyc + int'(LAT) + 2;
        sb.push_back(r);
      end else if (if_gnt) begin
        glog.push_back(1'b0);
        s.addr = if_addr; s.we = 1'b0; s.wdata = '0; s.due = cyc + 1;
        iq.push_back(s);
        r.is_data = 1'b0; r.data = mem_rd(if_addr); r.due = cyc + int'(LAT) + 2;
        sb.push_back(r);
      end
      if (m_req) begin
        check("m_req_expected", 64'(iq.size() != 0), 64'd1);
        if (iq.size() != 0) begin
          s = iq.pop_front();
          check("m_addr", 64'(m_addr), 64'(s.addr));
          check("m_we", 64'(m_we), 64'(s.we));
          check("m_wdata", 64'(m_wdata), 64'(s.wdata));
          check("m_req_cycle", 64'(cyc), 64'(s.due));
        end
      end
      check("rvalid_excl", 64'(if_rvalid & d_rvalid), 64'd0);
      if (if_rvalid || d_rvalid) begin
        check("rvalid_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          r = sb.pop_front();
          check("rsp_owner", 64'(d_rvalid), 64'(r.is_data));
          check("rsp_data", 64'(d_rvalid ? d_rdata : if_rdata), 64'(r.data));
          check("rsp_cycle", 64'(cyc), 64'(r.due));
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 64'({if_gnt, d_gnt, if_rvalid, d_rvalid, m_req, m_we, stall}), 64'd0);
    check({tag, "_if_rdata"}, 64'(if_rdata), 64'd0);
    check({tag, "_d_rdata"}, 64'(d_rdata), 64'd0);
    check({tag, "_m_addr"}, 64'(m_addr), 64'd0);
    check({tag, "_m_wdata"}, 64'(m_wdata), 64'd0);
    check({tag, "_perf"}, 64'(perf_if_gnt | perf_d_gnt | perf_stall), 64'd0);
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_zero("reset");
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while ((sb.size() != 0 || iq.size() != 0) && n < max_cyc) begin
      @(negedge clock);
      n++;
    end
    check("drain_timeout", 64'(n < max_cyc), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit pat [10];
    int n;
    pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    mem[32'h4] = 32'h8C01_0001;
    mem[32'h1] = 32'h0000_00AB;

    // Fetch only.
    do_reset();
    if_req = 1'b1; if_addr = 32'h4;
    @(negedge clock);
    check("f_if_gnt", 64'(if_gnt), 64'd1);
    check("f_d_gnt", 64'(d_gnt), 64'd0);
    check("f_stall_c0", 64'(stall), 64'd0);
    next_cycle();
    if_req = 1'b0; if_addr = '0;
    @(negedge clock);
    check("f_m_req", 64'(m_req), 64'd1);
    check("f_m_addr", 64'(m_addr), 64'h4);
    check("f_stall_c1", 64'(stall), 64'd1);
    repeat (3) next_cycle();
    @(negedge clock);
    check("f_if_rvalid", 64'(if_rvalid), 64'd1);
    check("f_if_rdata", 64'(if_rdata), 64'h8C01_0001);
    next_cycle();
    @(negedge clock);
    check("f_if_rvalid_off", 64'(if_rvalid), 64'd0);
    check("f_stall_c5", 64'(stall), 64'd0);

    // Load and fetch together: data wins, fetch follows.
    do_reset();
    d_req = 1'b1; d_addr = 32'h1; if_req = 1'b1; if_addr = 32'h40;
    @(negedge clock);
    check("lf_d_gnt", 64'(d_gnt), 64'd1);
    check("lf_if_gnt_c0", 64'(if_gnt), 64'd0);
    check("lf_stall_c0", 64'(stall), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      if (k == 1) begin d_req = 1'b0; d_addr = '0; end
      @(negedge clock);
      check("lf_stall_busy", 64'(stall), 64'd1);
      check("lf_if_gnt_busy", 64'(if_gnt), 64'd0);
    end
    check("lf_d_rvalid", 64'(d_rvalid), 64'd1);
    check("lf_d_rdata", 64'(d_rdata), 64'hAB);
    next_cycle();
    @(negedge clock);
    check("lf_if_gnt_c5", 64'(if_gnt), 64'd1);
    check("lf_stall_c5", 64'(stall), 64'd0);
    next_cycle();
    if_req = 1'b0; if_addr = '0;
    repeat (5) next_cycle();
    @(negedge clock);
    check("perf_if_gnt", 64'(perf_if_gnt), 64'(EXP_PIF));
    check("perf_d_gnt", 64'(perf_d_gnt), 64'(EXP_PD));
    check("perf_stall", 64'(perf_stall), 64'(EXP_PST));

    // Store: acknowledge only, load data register unchanged.
    next_cycle();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2; d_wdata = 32'h3C00;
    @(negedge clock);
    check("st_d_gnt", 64'(d_gnt), 64'd1);
    next_cycle();
    idle_inputs();
    @(negedge clock);
    check("st_m_we", 64'(m_we), 64'd1);
    check("st_m_wdata", 64'(m_wdata), 64'h3C00);
    repeat (3) next_cycle();
    @(negedge clock);
    check("st_d_rvalid", 64'(d_rvalid), 64'd1);
    check("st_d_rdata", 64'(d_rdata), 64'hAB);
    next_cycle();
    @(negedge clock);
    check("st_m_we_off", 64'(m_we), 64'd0);

    // Starvation: both held, fetch forced after each run of STARVE_MAX data grants.
    next_cycle();
    glog.delete();
    d_req = 1'b1; d_addr = 32'h10; if_req = 1'b1; if_addr = 32'h20;
    n = 0;
    while (glog.size() < 10 && n < 120) begin
      @(negedge clock);
      n++;
    end
    check("starve_count", 64'(glog.size() >= 10), 64'd1);
    next_cycle();
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      check("starve_seq", (i < glog.size()) ? 64'(glog[i]) : 64'hX, 64'(pat[i]));
    end
    wait_drain(40);

    // Reset during WAIT discards the in-flight fetch.
    next_cycle();
    if_req = 1'b1; if_addr = 32'h8;
    @(negedge clock);
    check("rw_if_gnt", 64'(if_gnt), 64'd1);
    next_cycle();
    idle_inputs();
    next_cycle();
    reset = 1'b1; if_req = 1'b1; d_req = 1'b1;
    @(negedge clock);
    check_zero("rw_mid");
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    @(negedge clock);
    check("rw_m_req_c3", 64'(m_req), 64'd0);
    next_cycle();
    @(negedge clock);
    check("rw_no_rvalid", 64'(if_rvalid | d_rvalid), 64'd0);
    next_cycle();
    if_req = 1'b1; if_addr = 32'hC;
    @(negedge clock);
    check("rw_regrant", 64'(if_gnt), 64'd1);
    next_cycle();
    idle_inputs();
    wait_drain(20);
    repeat (2) next_cycle();
    @(negedge clock);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
